// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : 32-bit signed multiply (radix-2 Booth) / divide (restoring), 33-cycle
//            latency. MULT_DIV_DIVZERO_EN enables early divide-by-zero completion.
// Revision : 1.0
// ============================================================================
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [5:0] C_LAST_ITER = 6'd31;

    state_t      r_state;
    state_t      w_nextState;
    logic [5:0]  r_count;
    // Shared datapath: r_acc is the Booth accumulator / partial remainder,
    // r_q the multiplier / dividend-quotient, r_b the multiplicand / |divisor|.
    logic [32:0] r_acc;
    logic [31:0] r_q;
    logic        r_qm1;
    logic [31:0] r_b;
    logic        r_negQ;
    logic        r_negR;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_lastIter;
    logic        w_bZero;
    logic        w_zeroSkip;
    logic [31:0] w_aMag;
    logic [31:0] w_bMag;
    logic [32:0] w_mExt;
    logic [32:0] w_boothSum;
    logic [32:0] w_mulAcc;
    logic [31:0] w_mulQ;
    logic [32:0] w_divShift;
    logic [32:0] w_divDiff;
    logic [32:0] w_divAcc;
    logic [31:0] w_divQ;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_lastIter = (r_count == C_LAST_ITER);
    assign w_bZero    = (r_b == 32'd0);
    assign w_aMag     = a_in[31] ? -a_in : a_in;
    assign w_bMag     = b_in[31] ? -b_in : b_in;

    // 33-bit accumulator keeps the -2^31 multiplicand case from overflowing.
    assign w_mExt = {r_b[31], r_b};

    always_comb begin
        w_boothSum = r_acc;
        case ({r_q[0], r_qm1})
            2'b01:   w_boothSum = r_acc + w_mExt;
            2'b10:   w_boothSum = r_acc - w_mExt;
            default: w_boothSum = r_acc;
        endcase
    end

    assign w_mulAcc = {w_boothSum[32], w_boothSum[32:1]};
    assign w_mulQ   = {w_boothSum[0], r_q[31:1]};

    assign w_divShift = {r_acc[31:0], r_q[31]};
    assign w_divDiff  = w_divShift - {1'b0, r_b};
    assign w_divAcc   = w_divDiff[32] ? w_divShift : w_divDiff;
    assign w_divQ     = {r_q[30:0], ~w_divDiff[32]};
    assign w_quot     = r_negQ ? -w_divQ : w_divQ;
    assign w_rem      = r_negR ? -w_divAcc[31:0] : w_divAcc[31:0];

`ifdef MULT_DIV_DIVZERO_EN
    logic r_divZero;

    assign w_zeroSkip = (r_state == DIV) && w_bZero;
    assign div_zero   = r_divZero;

    // Set only on the edge that enters DONE through the zero-divisor path.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_divZero <= 1'b0;
        end else begin
            r_divZero <= w_zeroSkip;
        end
    end
`else
    assign w_zeroSkip = 1'b0;
    assign div_zero   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = op ? DIV : MULT;
            MULT:    if (w_lastIter) w_nextState = DONE;
            DIV:     if (w_zeroSkip || w_lastIter) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_qm1   <= 1'b0;
            r_b     <= '0;
            r_negQ  <= 1'b0;
            r_negR  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_count <= '0;
                        r_acc   <= '0;
                        r_qm1   <= 1'b0;
                        if (op) begin
                            r_q    <= w_aMag;
                            r_b    <= w_bMag;
                            r_negQ <= a_in[31] ^ b_in[31];
                            r_negR <= a_in[31];
                        end else begin
                            r_q <= a_in;
                            r_b <= b_in;
                        end
                    end
                end
                MULT: begin
                    r_acc   <= w_mulAcc;
                    r_q     <= w_mulQ;
                    r_qm1   <= r_q[0];
                    r_count <= r_count + 6'd1;
                    if (w_lastIter) begin
                        r_hi <= w_mulAcc[31:0];
                        r_lo <= w_mulQ;
                    end
                end
                DIV: begin
                    if (!w_zeroSkip) begin
                        r_acc   <= w_divAcc;
                        r_q     <= w_divQ;
                        r_count <= r_count + 6'd1;
                        if (w_lastIter) begin
                            r_hi <= w_bZero ? 32'd0 : w_rem;
                            r_lo <= w_bZero ? 32'd0 : w_quot;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != IDLE);
    assign done   = (r_state == DONE);
    assign hi_out = r_hi;
    assign lo_out = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Brief    : Scoreboard bench for mult_div_unit (multiply, divide, div-by-zero,
//            ignored starts, result hold, reset abort).
// Revision : 1.0
// ============================================================================
module tb_mult_div_unit;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op    = 1'b0;
    logic [31:0] a_in  = '0;
    logic [31:0] b_in  = '0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int          nCmp = 0;
    int          nErr = 0;
    logic [31:0] mdlHi = '0;
    logic [31:0] mdlLo = '0;
    exp_t        sbq[$];

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    // Reference model + request. Called at a negedge with the unit idle; returns
    // at the negedge following the accept edge (edges after accept = 0).
    task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint pa;
        longint pb;
        longint r;
        longint q;
        pa    = longint'($signed(a));
        pb    = longint'($signed(b));
        e.dz  = 1'b0;
        e.lat = 32;
        if (!o) begin
            r     = pa * pb;
            mdlHi = r[63:32];
            mdlLo = r[31:0];
        end else if (b == 32'd0) begin
`ifdef MULT_DIV_DIVZERO_EN
            e.dz  = 1'b1;
            e.lat = 1;
`else
            mdlHi = '0;
            mdlLo = '0;
`endif
        end else begin
            q     = pa / pb;
            r     = pa % pb;
            mdlLo = q[31:0];
            mdlHi = r[31:0];
        end
        e.hi = mdlHi;
        e.lo = mdlLo;
        sbq.push_back(e);
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int k, output bit seen);
        k    = 0;
        seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                k    = i;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        op    = 1'b0;
        a_in  = 32'd5;
        b_in  = 32'd6;
        repeat (3) @(negedge clk);
        nCmp++; if (busy !== 1'b0) begin nErr++; $display("FAIL reset_busy: got %b expected 0", busy); end
        nCmp++; if (done !== 1'b0) begin nErr++; $display("FAIL reset_done: got %b expected 0", done); end
        nCmp++; if (div_zero !== 1'b0) begin nErr++; $display("FAIL reset_divzero: got %b expected 0", div_zero); end
        nCmp++; if (hi_out !== 32'd0) begin nErr++; $display("FAIL reset_hi: got %h expected 0", hi_out); end
        nCmp++; if (lo_out !== 32'd0) begin nErr++; $display("FAIL reset_lo: got %h expected 0", lo_out); end
        start = 1'b0;
        reset = 1'b0;
        mdlHi = '0;
        mdlLo = '0;
        @(negedge clk);
        nCmp++; if (busy !== 1'b0) begin nErr++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_mult();
        logic [31:0] ta[$];
        logic [31:0] tb[$];
        exp_t e;
        int   k;
        bit   seen;
        ta = '{32'd7, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'h7FFFFFFF};
        tb = '{32'hFFFFFFFD, 32'h80000000, 32'h12345678, 32'hFFFFFFFF, 32'h80000000};
        for (int i = 0; i < 3; i++) begin
            ta.push_back($urandom());
            tb.push_back($urandom());
        end
        foreach (ta[i]) begin
            issue(1'b0, ta[i], tb[i]);
            nCmp++; if (busy !== 1'b1) begin nErr++; $display("FAIL mult_busy[%0d]: got %b expected 1", i, busy); end
            wait_done(k, seen);
            e = sbq.pop_front();
            nCmp++; if (!seen || k != e.lat) begin nErr++; $display("FAIL mult_latency[%0d]: got %0d expected %0d", i, k, e.lat); end
            nCmp++; if (hi_out !== e.hi) begin nErr++; $display("FAIL mult_hi[%0d]: got %h expected %h", i, hi_out, e.hi); end
            nCmp++; if (lo_out !== e.lo) begin nErr++; $display("FAIL mult_lo[%0d]: got %h expected %h", i, lo_out, e.lo); end
            nCmp++; if (div_zero !== e.dz) begin nErr++; $display("FAIL mult_divzero[%0d]: got %b expected %b", i, div_zero, e.dz); end
            @(negedge clk);
            nCmp++; if ({done, busy} !== 2'b00) begin nErr++; $display("FAIL mult_pulse[%0d]: got done/busy %b expected 00", i, {done, busy}); end
        end
    endtask

    task automatic test_div();
        logic [31:0] ta[$];
        logic [31:0] tb[$];
        exp_t e;
        int   k;
        bit   seen;
        ta = '{32'hFFFFFFF9, 32'h80000000, 32'd100, 32'hFFFFFF9C, 32'd7, 32'h80000000, 32'h7FFFFFFF};
        tb = '{32'd2, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFF9, 32'hFFFFFF9C, 32'd1, 32'h80000000};
        for (int i = 0; i < 3; i++) begin
            ta.push_back($urandom());
            tb.push_back($urandom() | 32'd1);
        end
        foreach (ta[i]) begin
            issue(1'b1, ta[i], tb[i]);
            nCmp++; if (busy !== 1'b1) begin nErr++; $display("FAIL div_busy[%0d]: got %b expected 1", i, busy); end
            wait_done(k, seen);
            e = sbq.pop_front();
            nCmp++; if (!seen || k != e.lat) begin nErr++; $display("FAIL div_latency[%0d]: got %0d expected %0d", i, k, e.lat); end
            nCmp++; if (hi_out !== e.hi) begin nErr++; $display("FAIL div_rem[%0d]: got %h expected %h", i, hi_out, e.hi); end
            nCmp++; if (lo_out !== e.lo) begin nErr++; $display("FAIL div_quot[%0d]: got %h expected %h", i, lo_out, e.lo); end
            nCmp++; if (div_zero !== e.dz) begin nErr++; $display("FAIL div_divzero[%0d]: got %b expected %b", i, div_zero, e.dz); end
            @(negedge clk);
            nCmp++; if ({done, busy} !== 2'b00) begin nErr++; $display("FAIL div_pulse[%0d]: got done/busy %b expected 00", i, {done, busy}); end
        end
    endtask

    task automatic test_divzero();
        exp_t e;
        int   k;
        bit   seen;
        issue(1'b0, 32'd11, 32'd13);
        wait_done(k, seen);
        e = sbq.pop_front();
        nCmp++; if (lo_out !== e.lo) begin nErr++; $display("FAIL dz_setup_lo: got %h expected %h", lo_out, e.lo); end
        @(negedge clk);
        issue(1'b1, 32'd5, 32'd0);
        wait_done(k, seen);
        e = sbq.pop_front();
        nCmp++; if (!seen || k != e.lat) begin nErr++; $display("FAIL dz_latency: got %0d expected %0d", k, e.lat); end
        nCmp++; if (div_zero !== e.dz) begin nErr++; $display("FAIL dz_flag: got %b expected %b", div_zero, e.dz); end
        nCmp++; if (hi_out !== e.hi) begin nErr++; $display("FAIL dz_hi: got %h expected %h", hi_out, e.hi); end
        nCmp++; if (lo_out !== e.lo) begin nErr++; $display("FAIL dz_lo: got %h expected %h", lo_out, e.lo); end
        @(negedge clk);
        nCmp++; if ({done, busy} !== 2'b00) begin nErr++; $display("FAIL dz_pulse: got done/busy %b expected 00", {done, busy}); end
    endtask

    task automatic test_ignore_and_hold();
        exp_t e;
        int   k;
        bit   seen;
        issue(1'b0, 32'hFFFF0001, 32'h00012345);
        k    = 0;
        seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            if (i == 5) begin
                start = 1'b1;
                op    = 1'b1;
                a_in  = 32'd9;
                b_in  = 32'd3;
            end
            if (i == 6) start = 1'b0;
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                k    = i;
            end
        end
        e = sbq.pop_front();
        nCmp++; if (!seen || k != e.lat) begin nErr++; $display("FAIL ign_latency: got %0d expected %0d", k, e.lat); end
        nCmp++; if (hi_out !== e.hi) begin nErr++; $display("FAIL ign_hi: got %h expected %h", hi_out, e.hi); end
        nCmp++; if (lo_out !== e.lo) begin nErr++; $display("FAIL ign_lo: got %h expected %h", lo_out, e.lo); end
        // Request raised only during the DONE cycle must not be taken.
        start = 1'b1;
        op    = 1'b0;
        a_in  = 32'd2;
        b_in  = 32'd2;
        @(negedge clk);
        start = 1'b0;
        nCmp++; if (busy !== 1'b0) begin nErr++; $display("FAIL done_start_busy: got %b expected 0", busy); end
        repeat (4) @(negedge clk);
        nCmp++; if ({done, busy} !== 2'b00) begin nErr++; $display("FAIL hold_flags: got done/busy %b expected 00", {done, busy}); end
        nCmp++; if (hi_out !== e.hi) begin nErr++; $display("FAIL hold_hi: got %h expected %h", hi_out, e.hi); end
        nCmp++; if (lo_out !== e.lo) begin nErr++; $display("FAIL hold_lo: got %h expected %h", lo_out, e.lo); end
    endtask

    task automatic test_abort();
        exp_t e;
        int   k;
        bit   seen;
        int   nDone;
        issue(1'b0, 32'd7, 32'hFFFFFFFD);
        void'(sbq.pop_back());
        nDone = 0;
        for (int i = 1; i <= 9; i++) begin
            if (i == 3) begin
                start = 1'b1;
                op    = 1'b1;
                a_in  = 32'd40;
                b_in  = 32'd4;
            end
            if (i == 4) begin
                start = 1'b0;
                a_in  = 32'hDEADBEEF;
                b_in  = 32'h0BADF00D;
            end
            @(negedge clk);
            if (done) nDone++;
        end
        nCmp++; if (busy !== 1'b1 || nDone != 0) begin nErr++; $display("FAIL abort_pre: got busy %b dones %0d expected busy 1 dones 0", busy, nDone); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mdlHi = '0;
        mdlLo = '0;
        nCmp++; if ({busy, done, div_zero} !== 3'b000) begin nErr++; $display("FAIL abort_flags: got %b expected 000", {busy, done, div_zero}); end
        nCmp++; if (hi_out !== 32'd0) begin nErr++; $display("FAIL abort_hi: got %h expected 0", hi_out); end
        nCmp++; if (lo_out !== 32'd0) begin nErr++; $display("FAIL abort_lo: got %h expected 0", lo_out); end
        nDone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) nDone++;
        end
        nCmp++; if (nDone != 0) begin nErr++; $display("FAIL abort_no_done: got %0d active cycles expected 0", nDone); end
        issue(1'b0, 32'hFFFFFFFE, 32'd3);
        wait_done(k, seen);
        e = sbq.pop_front();
        nCmp++; if (!seen || k != e.lat) begin nErr++; $display("FAIL recover_latency: got %0d expected %0d", k, e.lat); end
        nCmp++; if ({hi_out, lo_out} !== {e.hi, e.lo}) begin nErr++; $display("FAIL recover_result: got %h_%h expected %h_%h", hi_out, lo_out, e.hi, e.lo); end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_divzero();
        test_ignore_and_hold();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
`default_nettype wire
